// File: rtl/line_writeback_pkg.sv
// Shared cache definitions: physical address type, AXI encodings, line geometry helpers.
// Used by both the stream buffer and the write-back buffer so they agree on layout.
package line_writeback_pkg;

  typedef logic [31:0] phys_t;

  localparam int AXI_ID_W = 4;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_ADDR = 2'd1,
    WB_DATA = 2'd2,
    WB_RESP = 2'd3
  } wb_state_e;

  function automatic int line_byte_offset(input int line_width);
    return $clog2(line_width / 8);
  endfunction

  function automatic int label_width(input int line_width);
    return $bits(phys_t) - line_byte_offset(line_width);
  endfunction

endpackage

// File: rtl/axi3_wr_if.sv
// AXI3 write-direction channels (AW/W/B) with 32-bit data.
interface axi3_wr_if;

  logic                                      awvalid;
  logic                                      awready;
  logic [line_writeback_pkg::AXI_ID_W-1:0]   awid;
  line_writeback_pkg::phys_t                 awaddr;
  logic [3:0]                                awlen;
  logic [2:0]                                awsize;
  logic [1:0]                                awburst;
  logic [1:0]                                awlock;
  logic [3:0]                                awcache;
  logic [2:0]                                awprot;

  logic                                      wvalid;
  logic                                      wready;
  logic [line_writeback_pkg::AXI_ID_W-1:0]   wid;
  logic [31:0]                               wdata;
  logic [3:0]                                wstrb;
  logic                                      wlast;

  logic                                      bvalid;
  logic                                      bready;
  logic [line_writeback_pkg::AXI_ID_W-1:0]   bid;
  logic [1:0]                                bresp;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
    input  awready,
    output wvalid, wid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
    output awready,
    input  wvalid, wid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );

endinterface

// File: rtl/line_writeback.sv
// Single-entry write-back buffer: one dirty line becomes one AXI3 INCR burst; the held line is snoopable.
// Latency: done 11 cycles after accept with a ready slave; each channel stalls freely on its ready/valid.
module line_writeback
  import line_writeback_pkg::*;
#(
  parameter int  LINE_WIDTH       = 256,
  parameter int  AWID             = 2,
  localparam int LINE_BYTE_OFFSET = line_byte_offset(LINE_WIDTH),
  localparam int LABEL_WIDTH      = label_width(LINE_WIDTH),
  localparam int BEATS            = LINE_WIDTH / 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_req,
  input  logic [LABEL_WIDTH-1:0] wb_label,
  input  logic [LINE_WIDTH-1:0]  wb_data,
  output logic                   wb_ready,
  output logic                   wb_done,
  output logic                   wb_err,
  input  logic [LABEL_WIDTH-1:0] lookup_label,
  output logic                   lookup_hit,
  output logic [LINE_WIDTH-1:0]  lookup_data,
  axi3_wr_if.master              axi
);

  localparam int                CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [AXI_ID_W-1:0] ID      = AXI_ID_W'(AWID);

  wb_state_e              state_q, state_d;
  logic [LABEL_WIDTH-1:0] label_q, label_d;
  logic [LINE_WIDTH-1:0]  data_q, data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   b_match;

  // Responses for other IDs are not ours; bready stays up so they drain.
  assign b_match = axi.bvalid && (axi.bid == ID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      label_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      label_q <= label_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    label_d = label_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (wb_req) begin
          label_d = wb_label;
          data_d  = wb_data;
          cnt_d   = '0;
          state_d = WB_ADDR;
        end
      end
      WB_ADDR: begin
        if (axi.awready) state_d = WB_DATA;
      end
      WB_DATA: begin
        if (axi.wready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) state_d = WB_RESP;
        end
      end
      WB_RESP: begin
        if (b_match) begin
          done_d  = 1'b1;
          err_d   = (axi.bresp == RESP_SLVERR) || (axi.bresp == RESP_DECERR);
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_comb begin
    axi.awvalid = (state_q == WB_ADDR);
    axi.wvalid  = (state_q == WB_DATA);
    axi.wlast   = (state_q == WB_DATA) && (cnt_q == LAST_BEAT);
    axi.bready  = (state_q == WB_RESP);
    wb_ready    = (state_q == WB_IDLE);
  end

  assign axi.awid    = ID;
  assign axi.awaddr  = {label_q, {LINE_BYTE_OFFSET{1'b0}}};
  assign axi.awlen   = 4'(BEATS - 1);
  assign axi.awsize  = SIZE_4B;
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.wid     = ID;
  assign axi.wdata   = data_q[32*cnt_q +: 32];
  assign axi.wstrb   = 4'hf;

  assign wb_done     = done_q;
  assign wb_err      = err_q;
  assign lookup_hit  = (state_q != WB_IDLE) && (lookup_label == label_q);
  assign lookup_data = data_q;

endmodule

// File: tb/tb_line_writeback.sv
// Randomized bench for line_writeback: AXI3 slave model with memory, scoreboard of issued lines.
module tb_line_writeback;
  import line_writeback_pkg::*;

  localparam int LW    = 256;
  localparam int AWID  = 2;
  localparam int LBW   = 27;
  localparam int BEATS = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_req;
  logic [LBW-1:0]  wb_label, lookup_label;
  logic [LW-1:0]   wb_data, lookup_data;
  logic            wb_ready, wb_done, wb_err, lookup_hit;

  always #5 clk = ~clk;

  axi3_wr_if axi();

  line_writeback #(.LINE_WIDTH(LW), .AWID(AWID)) dut (
    .clk(clk), .rst(rst), .wb_req(wb_req), .wb_label(wb_label), .wb_data(wb_data),
    .wb_ready(wb_ready), .wb_done(wb_done), .wb_err(wb_err),
    .lookup_label(lookup_label), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .axi(axi)
  );

  typedef struct {
    logic [LBW-1:0] label;
    logic [LW-1:0]  data;
    logic [1:0]     resp;
    bit             bad_first;
  } txn_t;

  txn_t        sb[$];
  int unsigned mem [int unsigned];
  int          assertions = 0;
  int          failures   = 0;
  int          cyc        = 0;
  int          acc_cyc    = 0;
  bit          t1_check   = 0;

  int  aw_delay = 0, b_delay = 0;
  bit  w_rand = 0;
  int  aw_wait, b_wait, w_beat;
  bit  b_pend, aw_stalled, w_stalled, aw_seen, bad_used, saw_bad;
  int unsigned w_base;
  logic [31:0] aw_prev, w_prev_data;
  logic        w_prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    assertions++;
    failures++;
    $display("FAIL timeout waiting for %s", name);
  endtask

  function automatic logic [31:0] word_of(input logic [LW-1:0] d, input int k);
    return 32'(d >> (32 * k));
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] d;
    for (int k = 0; k < BEATS; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  // Slave: readies chosen at each negedge; a handshake seen here completes at the next posedge.
  initial begin
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = '0; axi.bresp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        aw_wait = 0; b_wait = 0; w_beat = 0; b_pend = 0; aw_stalled = 0;
        w_stalled = 0; aw_seen = 0; bad_used = 0; saw_bad = 0;
        continue;
      end
      if (saw_bad) begin
        chk("bad_bid_still_resp", axi.bready, 1);
        chk("bad_bid_no_done", wb_done, 0);
        saw_bad = 0;
      end
      axi.bvalid = 0;
      if (b_pend) begin
        if (b_wait > 0) b_wait--;
        else begin
          bit bad;
          bad = (sb.size() > 0) && sb[0].bad_first && !bad_used;
          axi.bvalid = 1;
          axi.bid    = bad ? AXI_ID_W'(AWID ^ 1) : AXI_ID_W'(AWID);
          axi.bresp  = (sb.size() > 0) ? sb[0].resp : RESP_OKAY;
          if (axi.bready) begin
            if (bad) begin bad_used = 1; saw_bad = 1; end
            else b_pend = 0;
          end
        end
      end
      axi.wready = 0;
      if (aw_seen && w_beat > 0) chk("w_no_gap", axi.wvalid, 1);
      if (axi.wvalid) begin
        chk("w_after_aw", aw_seen, 1);
        if (w_stalled) begin
          chk("w_stable_data", axi.wdata, w_prev_data);
          chk("w_stable_last", axi.wlast, w_prev_last);
        end
        axi.wready = w_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (axi.wready) begin
          w_stalled = 0;
          if (sb.size() == 0) timeout("scoreboard entry for W");
          else begin
            chk("w_data", axi.wdata, word_of(sb[0].data, w_beat));
            chk("w_last", axi.wlast, (w_beat == BEATS - 1));
            chk("w_strb_id", {axi.wstrb, axi.wid}, {4'hf, 4'(AWID)});
          end
          mem[w_base + w_beat] = axi.wdata;
          w_beat++;
          if (axi.wlast) begin
            chk("w_beat_count", w_beat, BEATS);
            b_pend = 1; b_wait = b_delay; aw_seen = 0; w_beat = 0;
          end
        end else begin
          w_stalled = 1; w_prev_data = axi.wdata; w_prev_last = axi.wlast;
        end
      end
      axi.awready = 0;
      if (axi.awvalid) begin
        if (aw_stalled) chk("aw_stable_addr", axi.awaddr, aw_prev);
        if (aw_wait < aw_delay) begin
          aw_wait++; aw_stalled = 1; aw_prev = axi.awaddr;
        end else begin
          axi.awready = 1; aw_wait = 0; aw_stalled = 0;
          if (sb.size() == 0) timeout("scoreboard entry for AW");
          else chk("aw_addr", axi.awaddr, 32'(sb[0].label) * 32);
          chk("aw_len_size_burst", {axi.awlen, axi.awsize, axi.awburst}, {4'd7, 3'd2, 2'd1});
          chk("aw_id_attr", {axi.awid, axi.awlock, axi.awcache, axi.awprot}, {4'(AWID), 9'd0});
          w_base = axi.awaddr / 4; w_beat = 0; aw_seen = 1; bad_used = 0;
        end
      end
    end
  end

  // Monitor: every wb_done retires the oldest issued line.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && wb_done) begin
        if (sb.size() == 0) timeout("issued line matching wb_done");
        else begin
          txn_t t;
          int unsigned base;
          t = sb.pop_front();
          base = 32'(t.label) * 8;
          chk("done_err", wb_err, (t.resp == RESP_SLVERR) || (t.resp == RESP_DECERR));
          chk("ready_with_done", wb_ready, 1);
          for (int k = 0; k < BEATS; k++) chk("mem_word", mem[base + k], word_of(t.data, k));
          if (t1_check) begin
            chk("done_cycle", cyc - acc_cyc, 11);
            t1_check = 0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [LBW-1:0] l, input logic [LW-1:0] d,
                       input logic [1:0] r, input bit bad, input bit b2b);
    int n = 0;
    txn_t t;
    @(negedge clk);
    wb_req = 1; wb_label = l; wb_data = d;
    while (!wb_ready) begin
      @(negedge clk);
      n++;
      if (n > 500) begin timeout("wb_ready"); return; end
    end
    if (b2b) chk("b2b_accept_at_done", wb_done, 1);
    t.label = l; t.data = d; t.resp = r; t.bad_first = bad;
    sb.push_back(t);
    acc_cyc = cyc;
  endtask

  task automatic wait_for(input int sel, input string name);
    int n = 0;
    forever begin
      if ((sel == 0 && axi.awvalid) || (sel == 1 && axi.wvalid) || (sel == 2 && wb_done)) return;
      @(negedge clk);
      n++;
      if (n > 1000) begin timeout(name); return; end
    end
  endtask

  task automatic single(input logic [1:0] r, input bit bad);
    issue($urandom, rand_line(), r, bad, 0);
    @(negedge clk);
    wb_req = 0;
    wait_for(2, "wb_done");
  endtask

  initial begin
    logic [LW-1:0]  d;
    logic [LBW-1:0] l;
    int n;
    rst = 1; wb_req = 0; wb_label = '0; wb_data = '0; lookup_label = '0;
    @(negedge clk);
    chk("rst_ready", wb_ready, 1);
    chk("rst_done_err", {wb_done, wb_err}, 0);
    chk("rst_valids", {axi.awvalid, axi.wvalid, axi.wlast, axi.bready}, 0);
    chk("rst_lookup", {lookup_hit, lookup_data}, 0);
    rst = 0;

    for (int k = 0; k < BEATS; k++) d[32*k +: 32] = 32'h11111111 * (k + 1);
    t1_check = 1;
    issue(27'h40, d, RESP_OKAY, 0, 0);
    @(negedge clk);
    wb_req = 0;
    wait_for(0, "awvalid");
    chk("t1_awaddr", axi.awaddr, 32'h800);
    chk("t1_awlen", axi.awlen, 7);
    wait_for(2, "wb_done");

    l = $urandom; d = rand_line();
    issue(l, d, RESP_OKAY, 0, 0);
    @(negedge clk);
    wb_req = 0;
    wait_for(1, "wvalid");
    lookup_label = l;
    #1 chk("snoop_hit", lookup_hit, 1);
    chk("snoop_data", lookup_data, d);
    lookup_label = l ^ 1;
    #1 chk("snoop_miss_other", lookup_hit, 0);
    wait_for(2, "wb_done");
    lookup_label = l;
    #1 chk("snoop_miss_after_done", lookup_hit, 0);

    aw_delay = 3; w_rand = 1; b_delay = 5;
    repeat (3) single(RESP_OKAY, 0);
    aw_delay = 0; w_rand = 0; b_delay = 0;

    single(RESP_SLVERR, 1);
    single(RESP_DECERR, 0);
    single(2'b01, 1);

    for (int i = 0; i < 20; i++) issue($urandom, rand_line(), RESP_OKAY, 0, i > 0);
    @(negedge clk);
    wb_req = 0;
    wait_for(2, "wb_done");

    issue($urandom, rand_line(), RESP_OKAY, 0, 0);
    @(negedge clk);
    wb_req = 0;
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (w_beat >= 4 && axi.wvalid) break;
      n++;
      if (n > 200) begin timeout("beat 4"); break; end
    end
    rst = 1;
    #1 chk("midrst_valids", {axi.awvalid, axi.wvalid, axi.bready}, 0);
    chk("midrst_ready", wb_ready, 1);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    single(RESP_OKAY, 0);

    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #400000;
    timeout("end of test (watchdog)");
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
